// File: rtl/key_event_decoder.sv
// Purpose : turns a debounced key level into short / long / repeat / double-click pulses.
// Latency : every output is registered; a pulse appears the cycle after its triggering event.
// Backpr. : none; the key input is a level plus a settle strobe and cannot be stalled.
//
// Ports
//   sys_clk      : system clock, rising edge
//   sys_rst_n    : asynchronous active-low reset
//   key_value    : debounced key level (0 = pressed, 1 = released)
//   key_flag     : one-cycle strobe, key_value has just settled
//   short_press  : one-cycle pulse, single click confirmed after the double-click window
//   long_press   : one-cycle pulse, key held for LONG_CYC cycles
//   auto_repeat  : one-cycle pulse every REPEAT_CYC cycles while held after a long press
//   double_click : one-cycle pulse on release of the second press
//   busy         : high while a gesture is being tracked (state not IDLE)
//
// Parameters must lie in [2, 2^26 - 1]; the timer is 26 bits wide.

module key_event_decoder #(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DBL_CYC    = 15_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_value,
    input  logic key_flag,
    output logic short_press,
    output logic long_press,
    output logic auto_repeat,
    output logic double_click,
    output logic busy
);

    localparam int TIMER_W = 26;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    // Terminal counts: the timer reads 0 on the first cycle in a state, so
    // reaching N-1 means N cycles have elapsed and the move lands one later.
    localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_CYC - 1);
    localparam logic [TIMER_W-1:0] DBL_LAST    = TIMER_W'(DBL_CYC - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYC - 1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic               timer_wrap;
    logic               lvl;

    logic               press_evt;
    logic               release_evt;

    logic               short_nxt;
    logic               long_nxt;
    logic               repeat_nxt;
    logic               double_nxt;

    // Edges are taken against the last settled level, so a strobe that
    // re-reports the same level is not mistaken for a new press/release.
    assign press_evt   = key_flag & ~key_value &  lvl;
    assign release_evt = key_flag &  key_value & ~lvl;

    // ------------------------------------------------------------------
    // Next-state and pulse decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        timer_wrap = 1'b0;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        double_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (press_evt) begin
                    state_nxt = ST_PRESS1;
                end
            end

            ST_PRESS1: begin
                // A release on the long-press cycle counts as a click.
                if (release_evt) begin
                    state_nxt = ST_WAIT2;
                end else if (timer == LONG_LAST) begin
                    state_nxt = ST_LONG;
                    long_nxt  = 1'b1;
                end
            end

            ST_WAIT2: begin
                // A second press on the timeout cycle still makes a double click.
                if (press_evt) begin
                    state_nxt = ST_PRESS2;
                end else if (timer == DBL_LAST) begin
                    state_nxt = ST_IDLE;
                    short_nxt = 1'b1;
                end
            end

            ST_PRESS2: begin
                // Second-press hold time is deliberately not measured.
                if (release_evt) begin
                    state_nxt  = ST_IDLE;
                    double_nxt = 1'b1;
                end
            end

            ST_LONG: begin
                // Release ends the hold silently, even on a repeat cycle.
                if (release_evt) begin
                    state_nxt = ST_IDLE;
                end else if (timer == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                    timer_wrap = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timer restarts on any state change and on each repeat period.
    always_comb begin
        timer_nxt = timer + {{(TIMER_W-1){1'b0}}, 1'b1};
        if ((state_nxt != state) || timer_wrap) begin
            timer_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            timer <= '0;
            lvl   <= 1'b1;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (key_flag) begin
                lvl <= key_value;
            end
        end
    end

    // Outputs come from the decode above; at most one pulse source is set
    // per cycle because each branch raises a single flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            auto_repeat  <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            auto_repeat  <= repeat_nxt;
            double_click <= double_nxt;
            busy         <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Purpose : self-checking bench for key_event_decoder (directed gestures + random key traffic).
// Latency : expects every pulse one cycle after its triggering event.
// Backpr. : none.

module tb_key_event_decoder;

    localparam int LONG_CYC   = 100;
    localparam int DBL_CYC    = 40;
    localparam int REPEAT_CYC = 20;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_value = 1'b1;
    logic key_flag  = 1'b0;
    logic short_press;
    logic long_press;
    logic auto_repeat;
    logic double_click;
    logic busy;

    key_event_decoder #(
        .LONG_CYC  (LONG_CYC),
        .DBL_CYC   (DBL_CYC),
        .REPEAT_CYC(REPEAT_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_value   (key_value),
        .key_flag    (key_flag),
        .short_press (short_press),
        .long_press  (long_press),
        .auto_repeat (auto_repeat),
        .double_click(double_click),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // cyc names the cycle currently in progress; inputs set during cycle T
    // are sampled at the edge ending T, and their pulse is visible in T+1.
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %b, expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: gesture phases with timestamps. Deadlines are
    // computed from the cycle of the defining event, not from a counter.
    // ------------------------------------------------------------------
    localparam int PH_IDLE   = 0;
    localparam int PH_HELD   = 1;  // first press down
    localparam int PH_GAP    = 2;  // released, waiting for a second press
    localparam int PH_SECOND = 3;  // second press down
    localparam int PH_LONG   = 4;  // long press reached, repeating

    int   ph     = PH_IDLE;
    int   t_mark = 0;
    logic m_lvl  = 1'b1;
    logic e_sp   = 1'b0;
    logic e_lp   = 1'b0;
    logic e_rp   = 1'b0;
    logic e_dc   = 1'b0;

    wire m_press = key_flag && !key_value && m_lvl;
    wire m_rel   = key_flag &&  key_value && !m_lvl;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ph     <= PH_IDLE;
            t_mark <= 0;
            m_lvl  <= 1'b1;
            e_sp   <= 1'b0;
            e_lp   <= 1'b0;
            e_rp   <= 1'b0;
            e_dc   <= 1'b0;
        end else begin
            e_sp <= 1'b0;
            e_lp <= 1'b0;
            e_rp <= 1'b0;
            e_dc <= 1'b0;
            if (key_flag) m_lvl <= key_value;
            case (ph)
                PH_IDLE:
                    if (m_press) begin ph <= PH_HELD; t_mark <= cyc; end
                PH_HELD:
                    if (m_rel) begin
                        ph <= PH_GAP; t_mark <= cyc;
                    end else if (cyc == t_mark + LONG_CYC) begin
                        ph <= PH_LONG; e_lp <= 1'b1; t_mark <= cyc + 1;
                    end
                PH_GAP:
                    if (m_press) begin
                        ph <= PH_SECOND;
                    end else if (cyc == t_mark + DBL_CYC) begin
                        ph <= PH_IDLE; e_sp <= 1'b1;
                    end
                PH_SECOND:
                    if (m_rel) begin ph <= PH_IDLE; e_dc <= 1'b1; end
                PH_LONG:
                    if (m_rel) begin
                        ph <= PH_IDLE;
                    end else if ((cyc - t_mark) % REPEAT_CYC == REPEAT_CYC - 1) begin
                        e_rp <= 1'b1;
                    end
                default: ph <= PH_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model plus a pulse log for the
    // directed scenarios.
    int n_sp = 0, n_lp = 0, n_rp = 0, n_dc = 0;
    int last_sp = -1, last_lp = -1, last_rp = -1, last_dc = -1;

    always @(negedge sys_clk) begin
        if (cyc > 0) begin
            check_bit("short_press", short_press, e_sp);
            check_bit("long_press", long_press, e_lp);
            check_bit("auto_repeat", auto_repeat, e_rp);
            check_bit("double_click", double_click, e_dc);
            check_bit("busy", busy, ph != PH_IDLE);
            check_bit("one_pulse_max",
                      $countones({short_press, long_press, auto_repeat, double_click}) <= 1, 1'b1);
            if (short_press === 1'b1)  begin n_sp++; last_sp = cyc; end
            if (long_press === 1'b1)   begin n_lp++; last_lp = cyc; end
            if (auto_repeat === 1'b1)  begin n_rp++; last_rp = cyc; end
            if (double_click === 1'b1) begin n_dc++; last_dc = cyc; end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int b_sp, b_lp, b_rp, b_dc;

    task automatic snap();
        b_sp = n_sp; b_lp = n_lp; b_rp = n_rp; b_dc = n_dc;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic flag(input logic v);
        key_value = v;
        key_flag  = 1'b1;
        tick();
        key_flag  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int t0;
    int r0;
    int gap;
    logic v;

    initial begin
        // Reset state
        tick();
        @(negedge sys_clk);
        check_bit("reset_outputs_low",
                  |{short_press, long_press, auto_repeat, double_click, busy}, 1'b0);
        tick(); tick();
        sys_rst_n = 1'b1;
        run_to(cyc + 5);

        // Single short click
        snap(); t0 = cyc;
        flag(1'b0); run_to(t0 + 30); flag(1'b1); run_to(t0 + 80);
        check_int("s1_short_count", n_sp - b_sp, 1);
        check_int("s1_short_cycle", last_sp, t0 + 71);
        check_int("s1_other_pulses", (n_lp - b_lp) + (n_rp - b_rp) + (n_dc - b_dc), 0);

        // Double click
        snap(); t0 = cyc;
        flag(1'b0); run_to(t0 + 30); flag(1'b1);
        run_to(t0 + 50); flag(1'b0); run_to(t0 + 60); flag(1'b1);
        run_to(t0 + 120);
        check_int("s2_double_count", n_dc - b_dc, 1);
        check_int("s2_double_cycle", last_dc, t0 + 61);
        check_int("s2_no_short", n_sp - b_sp, 0);

        // Long press with auto-repeat
        snap(); t0 = cyc;
        flag(1'b0); run_to(t0 + 164);
        @(negedge sys_clk);
        check_bit("s3_busy_held", busy, 1'b1);
        run_to(t0 + 165); flag(1'b1);
        @(negedge sys_clk);
        check_bit("s3_busy_after_release", busy, 1'b0);
        run_to(t0 + 200);
        check_int("s3_long_count", n_lp - b_lp, 1);
        check_int("s3_long_cycle", last_lp, t0 + 101);
        check_int("s3_repeat_count", n_rp - b_rp, 3);
        check_int("s3_repeat_last", last_rp, t0 + 161);

        // Redundant flag while idle, then release one cycle before long
        snap();
        flag(1'b1); run_to(cyc + 3);
        @(negedge sys_clk);
        check_bit("s4_redundant_idle", busy, 1'b0);
        t0 = cyc;
        flag(1'b0); run_to(t0 + 99); flag(1'b1); run_to(t0 + 102);
        @(negedge sys_clk);
        check_bit("s4_in_wait2", busy, 1'b1);
        run_to(t0 + 150);
        check_int("s4_no_long", n_lp - b_lp, 0);
        check_int("s4_short_cycle", last_sp, t0 + 140);

        // Release exactly on the long-press cycle resolves as a click
        snap(); t0 = cyc;
        flag(1'b0); run_to(t0 + 100); flag(1'b1); run_to(t0 + 150);
        check_int("s4b_no_long", n_lp - b_lp, 0);
        check_int("s4b_short_cycle", last_sp, t0 + 141);

        // Second press on the WAIT2 timeout cycle
        snap(); t0 = cyc;
        flag(1'b0); run_to(t0 + 10); r0 = cyc; flag(1'b1);
        run_to(r0 + 40); flag(1'b0); run_to(r0 + 45); flag(1'b1);
        run_to(r0 + 100);
        check_int("s5_no_short", n_sp - b_sp, 0);
        check_int("s5_double_cycle", last_dc, r0 + 46);

        // Reset during PRESS1
        snap(); t0 = cyc;
        flag(1'b0); run_to(t0 + 20);
        sys_rst_n = 1'b0;
        tick();
        @(negedge sys_clk);
        check_bit("s6_outputs_in_reset",
                  |{short_press, long_press, auto_repeat, double_click, busy}, 1'b0);
        tick();
        sys_rst_n = 1'b1;
        run_to(cyc + 250);
        check_int("s6_no_pulse_after_reset",
                  (n_sp - b_sp) + (n_lp - b_lp) + (n_rp - b_rp) + (n_dc - b_dc), 0);
        snap(); t0 = cyc;
        flag(1'b0); run_to(t0 + 5); flag(1'b1); run_to(t0 + 60);
        check_int("s6_fresh_short_cycle", last_sp, t0 + 46);
        check_int("s6_fresh_short_count", n_sp - b_sp, 1);

        // Random key traffic, biased toward the timing boundaries
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       gap = LONG_CYC - 2 + int'($urandom_range(0, 2));
                1:       gap = DBL_CYC - 2 + int'($urandom_range(0, 2));
                2:       gap = REPEAT_CYC - 1 + int'($urandom_range(0, 1));
                default: gap = int'($urandom_range(1, 130));
            endcase
            run_to(cyc + gap);
            v = ($urandom_range(0, 5) == 0) ? key_value : ~key_value;
            flag(v);
            if ($urandom_range(0, 40) == 0) begin
                sys_rst_n = 1'b0;
                tick(); tick();
                sys_rst_n = 1'b1;
            end
        end
        run_to(cyc + 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYC, default 50_000_000, meaning hold cycles for a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter DBL_CYC, default 15_000_000, meaning the maximum release-to-second-press gap for a double click (300 ms).
REQ-003 SHALL have parameter REPEAT_CYC, default 10_000_000, meaning the auto-repeat period while held after a long press (200 ms).
REQ-004 SHALL have port sys_clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port key_value, input, 1 bit: debounced key level; 0 = pressed, 1 = released.
REQ-007 SHALL have port key_flag, input, 1 bit: one-cycle strobe marking key_value as newly settled.
REQ-008 SHALL have port short_press, output, 1 bit: one-cycle pulse for a single short click.
REQ-009 SHALL have port long_press, output, 1 bit: one-cycle pulse when the hold reaches LONG_CYC.
REQ-010 SHALL have port repeat, output, 1 bit: one-cycle pulse every REPEAT_CYC while held after a long press.
REQ-011 SHALL have port double_click, output, 1 bit: one-cycle pulse on release of the second press.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL keep an internal level register lvl (reset 1) that updates only on key_flag=1.
REQ-014 SHALL define the press event as key_flag=1 & key_value=0 & lvl=1, and the release event as key_flag=1 & key_value=1 & lvl=0; key_flag with an unchanged level SHALL be ignored.
REQ-015 SHALL use a 26-bit timer, cleared to 0 on every state change and incremented once per cycle otherwise.
REQ-016 SHALL implement states IDLE, PRESS1, WAIT2, PRESS2 and LONG, with all transitions occurring on the cycle after the triggering event.
REQ-017 In IDLE, a press event SHALL move the state to PRESS1; nothing else SHALL have any effect.
REQ-018 In PRESS1, a release event SHALL move the state to WAIT2.
REQ-019 In PRESS1 with timer==LONG_CYC-1 and no release event, the state SHALL move to LONG with long_press=1 for one cycle, i.e. LONG_CYC+1 cycles after the press-event cycle.
REQ-020 In PRESS1, a release event and the long condition in the same cycle SHALL resolve as a release: state WAIT2, no long_press.
REQ-021 In WAIT2, a press event SHALL move the state to PRESS2.
REQ-022 In WAIT2 with timer==DBL_CYC-1, the state SHALL move to IDLE with short_press=1, i.e. DBL_CYC+1 cycles after the release-event cycle.
REQ-023 In WAIT2, a simultaneous press event and timeout SHALL resolve as the press: PRESS2, no short_press.
REQ-024 In PRESS2, a release event SHALL move the state to IDLE with double_click=1; hold duration in PRESS2 is not measured and never produces long_press.
REQ-025 In LONG, when timer==REPEAT_CYC-1, repeat SHALL pulse next cycle and the timer SHALL wrap to 0.
REQ-026 In LONG, a release event SHALL move the state to IDLE with no pulse, and release SHALL win over a simultaneous repeat condition.
REQ-027 At most one output pulse SHALL be high in any cycle, and all outputs SHALL be registered.
REQ-028 The parameters SHALL satisfy 2 <= each < 2^26; other values are unsupported.

Reset
REQ-029 While sys_rst_n=0, short_press, long_press, repeat, double_click and busy SHALL be 0, the state IDLE, the timer 0 and lvl 1.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence with no pulse; after release, the first press event SHALL start a new sequence from IDLE.

Verification (LONG_CYC=100, DBL_CYC=40, REPEAT_CYC=20)
REQ-031 Press flag at T0, release flag at T0+30 -> short_press high only at T0+71; no other pulses.
REQ-032 Press at T0, release at T0+30, press at T0+50, release at T0+60 -> double_click only at T0+61; no short_press.
REQ-033 Press at T0, release at T0+165 -> long_press at T0+101, repeat at T0+121, T0+141 and T0+161, then busy=0 at T0+166.
REQ-034 Redundant key_flag with key_value=1 while idle, and release at exactly T0+99 after a press at T0 -> no pulses for the first, and WAIT2 with no long_press for the second.
REQ-035 In WAIT2, a press flag on the timeout cycle -> PRESS2 and no short_press; sys_rst_n pulsed low during PRESS1 -> all outputs 0 and no pulse afterward.
